// File: rtl/arm_mc_controller.sv
// Multicycle ARM control unit: main sequencing FSM, ALU decode, NZCV flags
// and condition gating of every architectural write.
module arm_mc_controller #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        Instr,
  input  logic [3:0]         ALUFlags,
  output logic               PCWrite,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic               MemWrite,
  output logic               AdrSrc,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ImmSrc,
  output logic [1:0]         RegSrc,
  output logic [1:0]         ALUControl,
  output logic [STATE_W-1:0] State
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  flags_q, flags_d;
  logic        condex_q, condex_d;

  logic [3:0]  cond;
  logic [1:0]  op;
  logic [5:0]  funct;
  logic        rd_is_pc;
  logic        next_pc, branch, reg_w, mem_w, alu_op;
  logic        no_write, dp_known;
  logic [1:0]  flag_w;
  logic        cond_ok;
  logic        unused_ok;

  assign cond      = Instr[31:28];
  assign op        = Instr[27:26];
  assign funct     = Instr[25:20];
  assign rd_is_pc  = (Instr[15:12] == 4'hF);
  assign unused_ok = ^{Instr[19:16], Instr[11:0]};

  // flags are {N, Z, C, V}
  function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'b0000: cond_eval = z;
      4'b0001: cond_eval = ~z;
      4'b0010: cond_eval = cy;
      4'b0011: cond_eval = ~cy;
      4'b0100: cond_eval = n;
      4'b0101: cond_eval = ~n;
      4'b0110: cond_eval = v;
      4'b0111: cond_eval = ~v;
      4'b1000: cond_eval = cy & ~z;
      4'b1001: cond_eval = ~cy | z;
      4'b1010: cond_eval = (n == v);
      4'b1011: cond_eval = (n != v);
      4'b1100: cond_eval = ~z & (n == v);
      4'b1101: cond_eval = z | (n != v);
      4'b1110: cond_eval = 1'b1;
      default: cond_eval = 1'b0;
    endcase
  endfunction

  assign cond_ok = cond_eval(cond, flags_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= FETCH;
      flags_q  <= 4'b0000;
      condex_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      flags_q  <= flags_d;
      condex_q <= condex_d;
    end
  end

  always_comb begin
    state_d    = FETCH;
    next_pc    = 1'b0;
    branch     = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    alu_op     = 1'b0;
    IRWrite    = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = 2'b00;
    dp_known   = 1'b0;
    flag_w     = 2'b00;
    flags_d    = flags_q;
    condex_d   = condex_q;

    case (state_q)
      FETCH: begin
        state_d   = DECODE;
        IRWrite   = reset;
        next_pc   = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        condex_d  = cond_ok;
        case (op)
          2'b01:   state_d = MEMADR;
          2'b00:   state_d = funct[5] ? EXECUTEI : EXECUTER;
          2'b10:   state_d = BRANCH;
          default: state_d = FETCH;
        endcase
      end
      MEMADR: begin
        state_d = funct[0] ? MEMREAD : MEMWRITE;
        ALUSrcB = 2'b01;
      end
      MEMREAD: begin
        state_d = MEMWB;
        AdrSrc  = 1'b1;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        reg_w     = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        mem_w  = 1'b1;
      end
      EXECUTER: begin
        state_d = ALUWB;
        alu_op  = 1'b1;
      end
      EXECUTEI: begin
        state_d = ALUWB;
        ALUSrcB = 2'b01;
        alu_op  = 1'b1;
      end
      ALUWB: begin
        reg_w = 1'b1;
      end
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch    = 1'b1;
      end
      default: state_d = FETCH;
    endcase

    // unrecognised data-processing commands fall back to ADD with no flag write
    if (alu_op) begin
      dp_known = 1'b1;
      case (funct[4:1])
        4'b0100: ALUControl = 2'b00;
        4'b0010: ALUControl = 2'b01;
        4'b0000: ALUControl = 2'b10;
        4'b1100: ALUControl = 2'b11;
        4'b1010: ALUControl = 2'b01;
        default: begin
          ALUControl = 2'b00;
          dp_known   = 1'b0;
        end
      endcase
      flag_w[1] = funct[0] & dp_known;
      flag_w[0] = funct[0] & dp_known & ~ALUControl[1];
      if (condex_q) begin
        if (flag_w[1]) flags_d[3:2] = ALUFlags[3:2];
        else           flags_d[3:2] = flags_q[3:2];
        if (flag_w[0]) flags_d[1:0] = ALUFlags[1:0];
        else           flags_d[1:0] = flags_q[1:0];
      end else begin
        flags_d = flags_q;
      end
    end else begin
      flag_w = 2'b00;
    end
  end

  // CMP is the only command that computes without writing back
  assign no_write = (op == 2'b00) && (funct[4:1] == 4'b1010);

  assign RegWrite = reset & reg_w & condex_q & ~no_write;
  assign MemWrite = reset & mem_w & condex_q;
  assign PCWrite  = reset & (next_pc | (condex_q & (branch | (reg_w & rd_is_pc))));
  assign ImmSrc   = op;
  assign RegSrc   = {op == 2'b01, op == 2'b10};
  assign State    = STATE_W'(state_q);

endmodule

// File: doc/arm_mc_controller.md
Name: arm_mc_controller

Overview:
- Control unit for the multicycle ARM datapath. The single-cycle core is being reworked so one shared memory serves instruction fetch and data access.
- Sequences each instruction through a main FSM and decodes ALU control.
- Holds the NZCV condition flags and gates all architectural writes with the evaluated condition.
- Drives only datapath mux selects and enables; it contains no datapath registers.

Parameters:
- STATE_W, 4, width of the state encoding and of the State debug port.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- Instr  input  32  instruction register contents; bits 31:12 used.
- ALUFlags  input  4  datapath ALU flags {N,Z,C,V}.
- PCWrite  output  1  PC register enable.
- IRWrite  output  1  instruction register enable.
- RegWrite  output  1  register file write enable.
- MemWrite  output  1  memory write enable.
- AdrSrc  output  1  memory address select: 0 = PC, 1 = ALU result.
- ALUSrcA  output  1  ALU A operand: 0 = Rn, 1 = PC.
- ALUSrcB  output  2  ALU B operand: 00 = Rm, 01 = extended immediate, 10 = constant 4.
- ResultSrc  output  2  result select: 00 = ALUOut register, 01 = Data register, 10 = ALU result.
- ImmSrc  output  2  immediate extend type; equals Instr[27:26].
- RegSrc  output  2  register address selects. RegSrc[0] = (op==10); RegSrc[1] = (op==01).
- ALUControl  output  2  00 = ADD, 01 = SUB, 10 = AND, 11 = ORR.
- State  output  STATE_W  current FSM state, for debug.

Behaviour:
- Field definitions: cond = Instr[31:28], op = Instr[27:26], funct = Instr[25:20], Rd = Instr[15:12].
- State encodings: FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4, MEMWRITE = 5, EXECUTER = 6, EXECUTEI = 7, ALUWB = 8, BRANCH = 9. Encodings 10–15 return to FETCH.
- Transitions:
  - FETCH → DECODE.
  - DECODE:
    - op = 01 → MEMADR.
    - op = 00 with funct[5] = 1 → EXECUTEI; with funct[5] = 0 → EXECUTER.
    - op = 10 → BRANCH.
    - op = 11 → FETCH; the instruction is treated as a NOP.
  - MEMADR: funct[0] = 1 (load) → MEMREAD; otherwise → MEMWRITE.
  - MEMREAD → MEMWB → FETCH.
  - MEMWRITE → FETCH.
  - EXECUTER and EXECUTEI → ALUWB → FETCH.
  - BRANCH → FETCH.
- Latency in cycles: LDR 5, STR 4, data-processing 4, B 3, op = 11 2.
- Per-state raw controls. Any control not listed for a state is 0.
  - FETCH: IRWrite = 1, NextPC = 1, AdrSrc = 0, ALUSrcA = 1, ALUSrcB = 10, ResultSrc = 10, ALUOp = 0.
  - DECODE: ALUSrcA = 1, ALUSrcB = 10, ResultSrc = 10.
  - MEMADR: ALUSrcA = 0, ALUSrcB = 01.
  - MEMREAD: AdrSrc = 1.
  - MEMWB: ResultSrc = 01, RegW = 1.
  - MEMWRITE: AdrSrc = 1, MemW = 1.
  - EXECUTER: ALUSrcB = 00, ALUOp = 1.
  - EXECUTEI: ALUSrcB = 01, ALUOp = 1.
  - ALUWB: ResultSrc = 00, RegW = 1.
  - BRANCH: ALUSrcB = 01, ResultSrc = 10, Branch = 1.
- ALU decode:
  - ALUOp = 0 → ALUControl = ADD, FlagW = 00.
  - ALUOp = 1 → decode on funct[4:1]:
    - 0100 → ADD.
    - 0010 → SUB.
    - 0000 → AND.
    - 1100 → ORR.
    - 1010 → CMP: SUB with NoWrite = 1, which suppresses RegW in ALUWB.
    - Any other value → ADD with FlagW = 00.
  - FlagW[1] = funct[0]. FlagW[0] = funct[0] & (ALUControl is ADD or SUB).
- Condition evaluation uses the Flags register:
  - EQ: Z. NE: ~Z. CS: C. CC: ~C. MI: N. PL: ~N. VS: V. VC: ~V.
  - HI: C & ~Z. LS: ~C | Z.
  - GE: N == V. LT: N != V.
  - GT: ~Z & (N == V). LE: Z | (N != V).
  - AL (1110): 1. 1111: 0.
- CondEx latching:
  - CondEx is registered at the end of DECODE and held until the next DECODE.
  - A flag update in EXECUTE therefore never affects the same instruction's ALUWB.
- Output gating:
  - RegWrite = RegW & CondEx & ~NoWrite.
  - MemWrite = MemW & CondEx.
  - PCWrite = NextPC | (CondEx & (Branch | (RegW & Rd == 15))).
- Flags update: on the clock edge ending EXECUTER or EXECUTEI, if CondEx = 1:
  - FlagW[1] loads N,Z from ALUFlags[3:2].
  - FlagW[0] loads C,V from ALUFlags[1:0].
- Reset behaviour (reset = 0):
  - State = FETCH, Flags = 0000, CondEx = 0, all taking effect immediately (asynchronous).
  - PCWrite, IRWrite, RegWrite and MemWrite are forced to 0 while reset is low.
  - Mux selects show FETCH values.
  - Reset asserted mid-instruction abandons the instruction; no partial write is issued.
- On reset release, the first rising edge executes FETCH.

Test Plan:
- Reset low for 3 cycles, then high → State = 0, all enables 0 during reset. First cycle after release: IRWrite = 1, PCWrite = 1. Sequence continues 0→1.
- ADD R1,R2,#5 (Instr = 0xE2821005) → states 0,1,7,8,0. ALUControl = 00 in state 7. RegWrite = 1 only in state 8. Flags unchanged.
- SUBS R0,R0,R0 with ALUFlags = 0100, then BEQ (0x0A000002) → Flags = 0100. BRANCH state has PCWrite = 1 and ALUSrcB = 01.
- BNE with Z = 1 → PCWrite = 0 in BRANCH. CMP R1,R1 (0xE1510001) → ALUWB has RegWrite = 0, Flags updated.
- LDR R3,[R4,#8] (0xE5943008) → states 0,1,2,3,4 with AdrSrc = 1 in state 3. RegWrite = 1 with ResultSrc = 01 in state 4.
- STREQ with Z = 0 → MemWrite stays 0. Reset pulsed during MEMWRITE → MemWrite drops to 0 immediately, State = 0.
